// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// Purpose:
//   UART transmitter that drains a first-word-fall-through byte FIFO. Whenever
//   it is idle, enabled and the FIFO reports data, it pops one word and sends
//   it as a start bit, DATA_SIZE data bits (LSB first) and STOP_BITS stop bits.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset (0 = in reset)
//   tx_enable     permission to start a new frame, looked at only in IDLE
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO read data, valid while fifo_empty = 0
//   fifo_read     one-cycle pop strobe to the FIFO
//   tx            registered serial line, idles high
//   busy          high while a frame is in progress (state != IDLE)
//   tx_done_tick  one-cycle pulse in the last clk of the final stop bit
//
// Handshake: the FIFO side acts as valid = ~fifo_empty and ready = IDLE &
//   tx_enable; a word transfers on the rising edge where fifo_read
//   (valid & ready) is high. fifo_data is captured on that same edge, so a
//   late-updating empty flag cannot cause a second pop: the FSM has already
//   left IDLE by the time the flag can be stale.
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_read,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);
    // Index of the final stop bit: 0 for one stop bit, 1 for two.
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_SIZE-1:0] shift, shift_next;
    logic                 stop_idx, stop_idx_next;
    logic                 tx_next;
    logic                 bit_end;

    assign busy    = (state != IDLE);
    assign bit_end = (cnt == CNT_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            shift    <= shift_next;
            stop_idx <= stop_idx_next;
            tx       <= tx_next;
        end
    end

    // Next-state, datapath updates and strobes.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CNT_W'(1);
        idx_next      = idx;
        shift_next    = shift;
        stop_idx_next = stop_idx;
        tx_next       = tx;
        fifo_read     = 1'b0;
        tx_done_tick  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next      = '0;
                idx_next      = '0;
                stop_idx_next = 1'b0;
                tx_next       = 1'b1;
                // Gated by reset so no word is popped (and lost) while the
                // block is held in reset.
                if (reset && tx_enable && !fifo_empty) begin
                    fifo_read  = 1'b1;
                    shift_next = fifo_data;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = shift[0];
                    state_next = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx == IDX_LAST) begin
                        tx_next       = 1'b1;
                        stop_idx_next = 1'b0;
                        state_next    = STOP;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        shift_next = shift >> 1;
                        tx_next    = shift_next[0];
                    end
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (stop_idx == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//
// Bench for uart_tx_fifo_drain with CLKS_PER_BIT = 4, DATA_SIZE = 8.
// dut1 uses one stop bit and is fed from a FIFO model whose empty flag lags
// a pop by one clock. dut2 uses two stop bits and is fed a stream of 0x00.
// Each pushed byte also pushes its expected line sequence (start, data LSB
// first, stop) to exp_q; the frame checker pops it when the pop strobe is
// seen and compares the line every clock of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    localparam int CPB   = 4;
    localparam int FRAME = (1 + 8 + 1) * CPB;  // 40 clocks per 8N1 frame

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- dut1 (8N1) ----------------
    logic       tx_enable  = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_read, tx, busy, tx_done_tick;

    uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .tx_enable    (tx_enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read    (fifo_read),
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick)
    );

    // ---------------- dut2 (8N2) ----------------
    logic       en2   = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       empty2;
    logic       read2, tx2, busy2, done2;
    int         cnt2  = 2;

    assign empty2 = (cnt2 == 0);
    always @(posedge clk) if (read2 && cnt2 > 0) cnt2 <= cnt2 - 1;

    uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .tx_enable    (en2),
        .fifo_empty   (empty2),
        .fifo_data    (data2),
        .fifo_read    (read2),
        .tx           (tx2),
        .busy         (busy2),
        .tx_done_tick (done2)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int frames = 0;
    int aborts = 0;
    int proto_bad = 0;
    int pop_cyc[$];
    logic [9:0] exp_q[$];
    logic [7:0] fifo_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- FIFO model with lagging flags ----------------
    // Flags reflect the occupancy before the current edge's pop, so the
    // empty flag rises one clock after the last word is popped.
    int fifo_n;
    always @(posedge clk) begin
        fifo_n = fifo_q.size();
        fifo_empty <= (fifo_n == 0);
        if (fifo_n > 0) fifo_data <= fifo_q[0];
        if (fifo_read) begin
            if (fifo_n == 0) proto_bad++;
            else void'(fifo_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] d, input logic [9:0] wave);
        fifo_q.push_back(d);
        exp_q.push_back(wave);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("frames_done", frames, target);
    endtask

    // ---------------- protocol watch on dut1 ----------------
    logic prev_read = 1'b0;
    always @(negedge clk) begin
        if (fifo_read && (busy || prev_read)) proto_bad++;
        prev_read = fifo_read;
    end

    // ---------------- frame checker (scoreboard consumer) ----------------
    initial begin : frame_checker
        logic [9:0] cur;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (reset && fifo_read) begin
                pops++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 1, 0);
                    cur = 10'h3FF;
                end else begin
                    cur = exp_q.pop_front();
                end
                aborted = 1'b0;
                for (int k = 1; k <= FRAME; k++) begin
                    @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    // {tx, busy, fifo_read, tx_done_tick}
                    check("frame_line", {tx, busy, fifo_read, tx_done_tick},
                          {cur[(k-1)/CPB], 1'b1, 1'b0, (k == FRAME)});
                end
                if (aborted) aborts++;
                else frames++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] wave;  // line sequence, bit 0 sent first
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        int base, n, p0, f0, gap, done_k;
        logic [43:0] w2;
        logic        seen;

        vecs[0] = '{data: 8'h01, wave: 10'h202};
        vecs[1] = '{data: 8'h80, wave: 10'h300};
        vecs[2] = '{data: 8'h5A, wave: 10'h2B4};
        vecs[3] = '{data: 8'h00, wave: 10'h200};

        // Reset with a word waiting and tx_enable high: nothing may pop.
        tx_enable = 1'b1;
        push_byte(8'hA5, 10'h34A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tx, busy, fifo_read, tx_done_tick}, 4'b1000);
        check("reset_outputs2", {tx2, busy2, read2, done2}, 4'b1000);

        // tx_enable low with FIFO non-empty: no pop.
        @(posedge clk); #1;
        tx_enable = 1'b0;
        reset     = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("disabled_no_pop", pops, 0);
        check("disabled_idle", {tx, busy, fifo_read}, 3'b100);

        // Raising tx_enable pops in that same cycle; the frame then follows.
        tx_enable = 1'b1;
        #1;
        check("pop_same_cycle", fifo_read, 1'b1);
        wait_frames(1, 100);

        // Table-driven back-to-back frames, pop period 41.
        base = pop_cyc.size();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_byte(vecs[i].data, vecs[i].wave);
        wait_frames(5, 4 * 45 + 20);
        for (int i = 1; i < 4; i++) begin
            if (pop_cyc.size() > base + i)
                check("pop_period", pop_cyc[base+i] - pop_cyc[base+i-1], FRAME + 1);
            else
                check("pop_missing", pop_cyc.size(), base + i + 1);
        end

        // Empty FIFO for 200 clocks: line stays idle.
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({tx, busy, fifo_read} !== 3'b100) n++;
        end
        check("empty_idle_hold", n, 0);

        // Reset during data bit 3 of 0xFF, then 0x3C goes out cleanly.
        p0 = pops;
        f0 = frames;
        @(posedge clk); #1;
        push_byte(8'hFF, 10'h3FE);
        push_byte(8'h3C, 10'h278);
        n = 0;
        while (pops == p0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("ff_popped", pops, p0 + 1);
        repeat (17) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {tx, busy, fifo_read, tx_done_tick}, 4'b1000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_frames(f0 + 1, 100);
        check("aborted_frames", aborts, 1);
        check("total_pops", pops, 7);
        check("exp_q_drained", exp_q.size(), 0);

        // dut2: two stop bits, stream of 0x00.
        @(posedge clk); #1;
        en2  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (read2) seen = 1'b1;
        end
        check("s2_first_pop", seen, 1'b1);
        done_k = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            w2[k-1] = tx2;
            if (done2) done_k = k;
        end
        check("s2_wave", w2, {8'hFF, 36'h0});
        check("s2_done_pos", done_k, 44);
        gap  = 44;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            gap++;
            if (read2) seen = 1'b1;
        end
        check("s2_pop_period", gap, 45);
        repeat (50) @(posedge clk);

        check("protocol", proto_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
